// File: rtl/lcd_send_arbiter_if.sv
// Requester-side and LCD-engine-side signals of the send arbiter, bundled as one interface.
// The arbiter uses the slave view; the driving environment uses the master view.
interface lcd_send_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int TEXT_W = 128
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*TEXT_W-1:0] req_text;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        done;
  logic                    timeout;
  logic                    err;
  logic                    busy;
  logic                    send_text;
  logic [TEXT_W-1:0]       text;
  logic                    sending_done;

  modport slave (
    input  req, req_text, sending_done,
    output grant, done, timeout, err, busy, send_text, text
  );

  modport master (
    output req, req_text, sending_done,
    input  grant, done, timeout, err, busy, send_text, text
  );
endinterface

// File: rtl/lcd_send_arbiter.sv
// Round-robin arbiter sharing one LCD text engine between N_REQ requesters,
// with launch pulse, completion/timeout release and a hold-off gap between grants.
module lcd_send_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TEXT_W  = 128,
  parameter int TIMEOUT = 2000000,
  parameter int HOLDOFF = 16
) (
  input logic              CLK,
  input logic              RST,
  lcd_send_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(HOLDOFF + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST   = GW'(HOLDOFF - 1);
  localparam logic [PW-1:0] PTR_INIT   = PW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

  state_t              state;
  logic [PW-1:0]       ptr;
  logic [TW-1:0]       timer;
  logic [GW-1:0]       gap_cnt;
  logic [N_REQ-1:0]    grant_q;
  logic [N_REQ-1:0]    done_q;
  logic                timeout_q;
  logic                err_q;
  logic                busy_q;
  logic                send_q;
  logic [TEXT_W-1:0]   text_q;

  logic                found;
  logic [PW-1:0]       win;

  // Searches downward in distance so the requester nearest after p is written last and wins.
  function automatic logic [PW:0] pick(input logic [N_REQ-1:0] r, input logic [PW-1:0] p);
    logic [PW:0] res;
    int idx;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(p) + k) % N_REQ;
      if (r[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    {found, win} = pick(bus.req, ptr);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= PTR_INIT;
      timer     <= '0;
      gap_cnt   <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      send_q    <= 1'b0;
      text_q    <= '0;
    end else begin
      send_q    <= 1'b0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_q <= ONE_HOT0 << win;
            text_q  <= bus.req_text[int'(win)*TEXT_W +: TEXT_W];
            busy_q  <= 1'b1;
            send_q  <= 1'b1;
            ptr     <= win;
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Completion takes priority over the timeout on the last permitted cycle.
          if (bus.sending_done) begin
            done_q  <= grant_q;
            grant_q <= '0;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (timer >= TIMER_LAST) begin
            done_q    <= grant_q;
            timeout_q <= 1'b1;
            err_q     <= 1'b1;
            grant_q   <= '0;
            gap_cnt   <= '0;
            state     <= GAP;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt >= GAP_LAST) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.send_text = send_q;
  assign bus.text      = text_q;

endmodule

// File: tb/tb_lcd_send_arbiter.sv
// Directed bench for lcd_send_arbiter with TIMEOUT=20, HOLDOFF=4, N_REQ=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_lcd_send_arbiter;
  localparam int N_REQ   = 4;
  localparam int TEXT_W  = 128;
  localparam int TIMEOUT = 20;
  localparam int HOLDOFF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests_run = 0;
  int tests_failed = 0;

  logic [127:0] t0, t1, t2;
  logic [3:0] rr_exp [5];

  lcd_send_arbiter_if #(.N_REQ(N_REQ), .TEXT_W(TEXT_W)) bus();

  lcd_send_arbiter #(
    .N_REQ(N_REQ), .TEXT_W(TEXT_W), .TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic sd);
    bus.req = r;
    bus.sending_done = sd;
  endtask

  task automatic setText(input int i, input logic [127:0] t);
    bus.req_text[i*TEXT_W +: TEXT_W] = t;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Pulses sending_done in the current WAIT cycle, then checks release and the hold-off gap.
  task automatic finishTxn(input logic [3:0] exp_done, input string tag);
    bus.sending_done = 1'b1;
    tick();
    bus.sending_done = 1'b0;
    checkOutput({tag, "_done"}, bus.done, exp_done);
    checkOutput({tag, "_timeout"}, bus.timeout, 1'b0);
    checkOutput({tag, "_grant_clr"}, bus.grant, 4'b0000);
    checkOutput({tag, "_busy_gap"}, bus.busy, 1'b1);
    repeat (HOLDOFF) tick();
    checkOutput({tag, "_busy_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    t0 = "0123456789123456";
    t1 = "HELLO WORLD 1234";
    t2 = "CHANGED TEXT XYZ";
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    bus.req_text = '0;

    // Reset state
    doReset();
    checkOutput("rst_grant", bus.grant, 4'b0000);
    checkOutput("rst_done", bus.done, 4'b0000);
    checkOutput("rst_timeout", bus.timeout, 1'b0);
    checkOutput("rst_err", bus.err, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_send", bus.send_text, 1'b0);
    checkOutput("rst_text", bus.text, 128'd0);

    // Single request, sending_done at cycle 10
    setText(0, t0);
    applyStimulus(4'b0001, 1'b0);
    tick();
    checkOutput("t1_grant_c1", bus.grant, 4'b0001);
    checkOutput("t1_send_c1", bus.send_text, 1'b1);
    checkOutput("t1_busy_c1", bus.busy, 1'b1);
    checkOutput("t1_text_c1", bus.text, t0);
    for (int c = 2; c <= 10; c++) begin
      tick();
      checkOutput($sformatf("t1_grant_c%0d", c), bus.grant, 4'b0001);
      checkOutput($sformatf("t1_send_c%0d", c), bus.send_text, 1'b0);
    end
    bus.sending_done = 1'b1;
    tick();
    bus.sending_done = 1'b0;
    checkOutput("t1_done_c11", bus.done, 4'b0001);
    checkOutput("t1_grant_c11", bus.grant, 4'b0000);
    checkOutput("t1_timeout_c11", bus.timeout, 1'b0);
    checkOutput("t1_busy_c11", bus.busy, 1'b1);
    checkOutput("t1_text_c11", bus.text, t0);
    for (int c = 12; c <= 14; c++) begin
      tick();
      checkOutput($sformatf("t1_busy_c%0d", c), bus.busy, 1'b1);
      checkOutput($sformatf("t1_done_c%0d", c), bus.done, 4'b0000);
    end
    tick();
    checkOutput("t1_busy_c15", bus.busy, 1'b0);
    checkOutput("t1_grant_c15", bus.grant, 4'b0000);
    tick();
    checkOutput("t1_regrant_c16", bus.grant, 4'b0001);
    checkOutput("t1_resend_c16", bus.send_text, 1'b1);
    applyStimulus(4'b0000, 1'b0);
    tick();
    finishTxn(4'b0001, "t1b");

    // Round-robin with all requesters held, sending_done 5 cycles after each launch
    doReset();
    applyStimulus(4'b1111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("rr_grant_%0d", i), bus.grant, rr_exp[i]);
      checkOutput($sformatf("rr_onehot_%0d", i), 128'($countones(bus.grant)), 128'd1);
      if (i == 4) applyStimulus(4'b0000, 1'b0);
      repeat (5) tick();
      checkOutput($sformatf("rr_hold_%0d", i), bus.grant, rr_exp[i]);
      finishTxn(rr_exp[i], $sformatf("rr%0d", i));
    end

    // Timeout: requester 1, no sending_done
    applyStimulus(4'b0010, 1'b0);
    tick();
    checkOutput("to_grant_c1", bus.grant, 4'b0010);
    applyStimulus(4'b0000, 1'b0);
    repeat (20) tick();
    checkOutput("to_grant_c21", bus.grant, 4'b0010);
    checkOutput("to_done_c21", bus.done, 4'b0000);
    checkOutput("to_err_c21", bus.err, 1'b0);
    tick();
    checkOutput("to_done_c22", bus.done, 4'b0010);
    checkOutput("to_timeout_c22", bus.timeout, 1'b1);
    checkOutput("to_err_c22", bus.err, 1'b1);
    checkOutput("to_grant_c22", bus.grant, 4'b0000);
    tick();
    checkOutput("to_timeout_c23", bus.timeout, 1'b0);
    checkOutput("to_done_c23", bus.done, 4'b0000);
    checkOutput("to_err_c23", bus.err, 1'b1);
    repeat (3) tick();
    checkOutput("to_busy_c26", bus.busy, 1'b0);

    // Requester changes text and drops req after grant
    setText(0, t1);
    applyStimulus(4'b0001, 1'b0);
    tick();
    checkOutput("mb_grant_c1", bus.grant, 4'b0001);
    checkOutput("mb_text_c1", bus.text, t1);
    setText(0, t2);
    tick();
    tick();
    applyStimulus(4'b0000, 1'b0);
    checkOutput("mb_text_c3", bus.text, t1);
    tick();
    checkOutput("mb_grant_c4", bus.grant, 4'b0001);
    checkOutput("mb_text_c4", bus.text, t1);
    tick();
    finishTxn(4'b0001, "mb");
    checkOutput("mb_text_after", bus.text, t1);
    checkOutput("mb_err_sticky", bus.err, 1'b1);

    // Boundary: sending_done during LAUNCH ignored, on final WAIT cycle is normal
    doReset();
    checkOutput("bd_err_rst", bus.err, 1'b0);
    setText(0, t0);
    applyStimulus(4'b0001, 1'b0);
    tick();
    checkOutput("bd_send_c1", bus.send_text, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    tick();
    bus.sending_done = 1'b0;
    checkOutput("bd_grant_c2", bus.grant, 4'b0001);
    checkOutput("bd_done_c2", bus.done, 4'b0000);
    repeat (19) tick();
    checkOutput("bd_grant_c21", bus.grant, 4'b0001);
    checkOutput("bd_done_c21", bus.done, 4'b0000);
    bus.sending_done = 1'b1;
    tick();
    bus.sending_done = 1'b0;
    checkOutput("bd_done_c22", bus.done, 4'b0001);
    checkOutput("bd_timeout_c22", bus.timeout, 1'b0);
    checkOutput("bd_err_c22", bus.err, 1'b0);
    checkOutput("bd_grant_c22", bus.grant, 4'b0000);
    repeat (HOLDOFF) tick();
    checkOutput("bd_busy_idle", bus.busy, 1'b0);

    // Reset in the middle of WAIT
    doReset();
    setText(2, t1);
    setText(3, t2);
    applyStimulus(4'b1100, 1'b0);
    tick();
    checkOutput("rw_grant_c1", bus.grant, 4'b0100);
    checkOutput("rw_text_c1", bus.text, t1);
    repeat (4) tick();
    checkOutput("rw_grant_c5", bus.grant, 4'b0100);
    rst = 1'b1;
    #1;
    checkOutput("rw_async_grant", bus.grant, 4'b0000);
    checkOutput("rw_async_busy", bus.busy, 1'b0);
    checkOutput("rw_async_text", bus.text, 128'd0);
    checkOutput("rw_async_done", bus.done, 4'b0000);
    checkOutput("rw_async_send", bus.send_text, 1'b0);
    tick();
    checkOutput("rw_nodone", bus.done, 4'b0000);
    rst = 1'b0;
    tick();
    checkOutput("rw_regrant0", bus.grant, 4'b0100);
    tick();
    finishTxn(4'b0100, "rw0");
    tick();
    checkOutput("rw_regrant1", bus.grant, 4'b1000);
    checkOutput("rw_text1", bus.text, t2);
    applyStimulus(4'b0000, 1'b0);
    tick();
    finishTxn(4'b1000, "rw1");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/lcd_send_arbiter.md
# lcd_send_arbiter

Shares the single LCD text-sending engine between up to N_REQ requesters, such as button handlers and status reporters. It arbitrates round-robin and latches the winner's 16-character text. It then issues the engine's send pulse, waits for the engine's done pulse or a timeout, and enforces a hold-off gap before the next grant. It sits between the debounced-button and application logic and the LCD engine's `sendText`/`text`/`sendingDone` handshake.

## Interface
Parameters:
- N_REQ, 4, number of requesters (≥2)
- TEXT_W, 128, text width in bits (16 chars × 8)
- TIMEOUT, 2000000, maximum WAIT cycles before forced release (≥1)
- HOLDOFF, 16, idle gap cycles after each release (≥1)

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- req  in  N_REQ  level request, one bit per requester
- req_text  in  N_REQ*TEXT_W  packed text; requester i at [i*TEXT_W +: TEXT_W]
- grant  out  N_REQ  one-hot owner, held for the whole transaction
- done  out  N_REQ  one-cycle pulse to owner at release
- timeout  out  1  one-cycle pulse, coincident with done, when release was forced
- err  out  1  sticky timeout flag, cleared only by RST
- busy  out  1  high from grant through end of hold-off
- send_text  out  1  one-cycle launch pulse to LCD engine
- text  out  TEXT_W  latched text to engine, stable from launch until next grant
- sending_done  in  1  completion pulse from LCD engine

## Operation
- All outputs registered. Reset values: grant=0, done=0, timeout=0, err=0, busy=0, send_text=0, text=0, state=IDLE, timer=0, rr pointer=N_REQ-1, so requester 0 has first priority.
- States: IDLE, LAUNCH, WAIT, GAP.
- IDLE with any req bit set:
  - Pick the first set bit searching from pointer+1 upward, with wrap.
  - Set grant one-hot, latch req_text slice into text, set busy.
  - Pointer := winner; go to LAUNCH.
- LAUNCH:
  - send_text=1 for exactly this cycle; timer := 0; go to WAIT.
- WAIT:
  - sending_done=1 → release (normal).
  - Otherwise timer increments. TIMEOUT WAIT cycles elapsed without sending_done → release (forced); err := 1.
- Release, the first GAP cycle:
  - done[owner]=1 for one cycle; timeout=1 only if forced.
  - grant := 0; text holds.
- GAP lasts HOLDOFF cycles with busy=1, then IDLE with busy=0.
- Dropping req mid-transaction does not abort; the transaction completes and done still pulses. req_text changes after the latch are ignored.
- sending_done outside WAIT, including during LAUNCH, is ignored.
- sending_done on the final permitted WAIT cycle: normal completion, no timeout.
- Timer width $clog2(TIMEOUT+1); saturating compare, no wrap.
- RST asserted mid-operation: immediate return to reset values. No done pulse for the aborted transaction.

## Timing
Cycle 0 = the IDLE cycle where req is sampled.
- Cycle 1: grant, text, busy valid; send_text=1.
- Cycles 2 … : WAIT.
- sending_done at cycle m → cycle m+1: done pulse, grant=0. GAP spans m+1 … m+HOLDOFF. IDLE at m+HOLDOFF+1. Earliest next grant at m+HOLDOFF+2.
- No sending_done: WAIT spans cycles 2 … TIMEOUT+1. Release with timeout at cycle TIMEOUT+2.
- Arbitration latency from req to grant: 1 cycle when IDLE.

## Test plan
Bench parameters: TIMEOUT=20, HOLDOFF=4, N_REQ=4.
- Single request: req=0001 with text "0123456789123456", sending_done at cycle 10 → grant=0001 on cycles 1–10; send_text high on cycle 1 only; text matches; done=0001 on cycle 11; busy low on cycle 15; re-grant at cycle 16 if req is held.
- Round-robin: req=1111 held, sending_done 5 cycles after each launch → grant sequence 0001, 0010, 0100, 1000, 0001; never two bits set.
- Timeout: req=0010, sending_done never → done=0010 and timeout=1 at cycle 22; err=1 stays high through later normal transactions.
- Boundary: sending_done on cycles 1 (LAUNCH) and 21 → cycle 1 pulse ignored; cycle 21 gives normal release at cycle 22, timeout=0, err=0.
- Requester misbehaviour: after grant, change req_text and drop req at cycle 3 → text unchanged; done still pulses after sending_done.
- Reset mid-WAIT: RST at cycle 5 with req=1100 → all outputs 0 asynchronously, no done pulse. After release, first grant=0100 (pointer reset), then 1000.
